// File: rtl/sram_bus_arbiter.sv
// ---------------------------------------------------------------------------
// sram_bus_arbiter
//
// Shares the single nak-handshake SRAM controller port between several bus
// masters (CPU data, CPU instruction fetch, SD/VGA DMA). Fresh arbitration is
// round-robin. Once a request is issued and the slave naks it, the grant stays
// with that master, so one request is never split across owners. Read data is
// broadcast to every master; only the owner sees its nak drop.
//
// Ports
//   clk, rst   system clock, synchronous active-high reset
//   m_en       per-master request, held until that master sees nak low
//   m_we       per-master write strobe
//   m_addr     packed master addresses, master i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   m_wdata    packed master write data, master i at [i*DATA_WIDTH +: DATA_WIDTH]
//   m_nak      per-master nak for the request that master issued last cycle
//   m_rdata    read data broadcast to all masters
//   s_en       slave request
//   s_we       slave write strobe
//   s_addr     slave address
//   s_wdata    slave write data
//   s_rdata    slave read data, valid the cycle after s_en
//   s_nak      slave nak for the request issued last cycle
// ---------------------------------------------------------------------------
module sram_bus_arbiter #(
  parameter int NUM_MASTERS = 3,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_MASTERS-1:0]            m_en,
  input  logic [NUM_MASTERS-1:0]            m_we,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]            m_nak,
  output logic [DATA_WIDTH-1:0]             m_rdata,
  output logic                              s_en,
  output logic                              s_we,
  output logic [ADDR_WIDTH-1:0]             s_addr,
  output logic [DATA_WIDTH-1:0]             s_wdata,
  input  logic [DATA_WIDTH-1:0]             s_rdata,
  input  logic                              s_nak
);

  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_MASTERS - 1);

  logic [NUM_MASTERS-1:0] req_q;
  logic                   own_v;
  logic [IW-1:0]          own_idx;
  logic [IW-1:0]          rr_ptr;
  logic [IW-1:0]          rr_next;
  logic [IW-1:0]          grant;
  logic                   lock;
  logic                   done;

  // lock: the owner's last request was naked and must be repeated to the
  // same master. done: the owner's last request completed this cycle.
  assign lock = own_v & s_nak;
  assign done = own_v & ~s_nak;

  // Pointer advance on completion is made visible to this cycle's fresh
  // arbitration; otherwise a master finishing a transfer would win again the
  // very next cycle and continuous requesters would not rotate strictly.
  always_comb begin
    rr_next = rr_ptr;
    if (done) begin
      rr_next = (own_idx == LAST_IDX) ? '0 : own_idx + IW'(1);
    end
  end

  // Grant selection: a locked owner that still requests keeps the port,
  // otherwise scan from rr_next upward with wrap and take the first requester.
  // With no request the grant rests on rr_next (slave-side values then
  // are don't care).
  always_comb begin
    logic [IW:0] idx;
    logic        found;
    grant = rr_next;
    found = 1'b0;
    idx   = '0;
    if (lock && m_en[own_idx]) begin
      grant = own_idx;
    end else begin
      for (int k = 0; k < NUM_MASTERS; k++) begin
        idx = {1'b0, rr_next} + (IW+1)'(k);
        if (idx >= (IW+1)'(NUM_MASTERS)) begin
          idx = idx - (IW+1)'(NUM_MASTERS);
        end
        if (!found && m_en[idx[IW-1:0]]) begin
          grant = idx[IW-1:0];
          found = 1'b1;
        end
      end
    end
  end

  // Slave-side mux from the granted master, with constant slice bounds.
  always_comb begin
    s_en    = (|m_en) & ~rst;
    s_we    = m_we[0];
    s_addr  = m_addr[0 +: ADDR_WIDTH];
    s_wdata = m_wdata[0 +: DATA_WIDTH];
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant == IW'(i)) begin
        s_we    = m_we[i];
        s_addr  = m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        s_wdata = m_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Every master that requested last cycle is naked unless it is the owner
  // and the slave completed it. Suppressed entirely while in reset.
  always_comb begin
    m_nak = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      m_nak[i] = ~rst & req_q[i] & ~(done & (own_idx == IW'(i)));
    end
  end

  assign m_rdata = s_rdata;

  // State update. Reset drops any outstanding request, so no nak is reported
  // for it after reset releases.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q   <= '0;
      own_v   <= 1'b0;
      own_idx <= '0;
      rr_ptr  <= '0;
    end else begin
      req_q   <= m_en;
      own_v   <= s_en;
      own_idx <= grant;
      rr_ptr  <= rr_next;
    end
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_bus_arbiter
//
// Directed bench for sram_bus_arbiter with three masters. Inputs change on
// the falling edge; combinational outputs are compared 1 ns later, well away
// from the rising edge. Each cycle lists the expected grant index, s_en and
// m_nak; s_addr/s_we/s_wdata are expected from the granted master's inputs.
// ---------------------------------------------------------------------------
module tb_sram_bus_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk;
  logic            rst;
  logic [N-1:0]    m_en;
  logic [N-1:0]    m_we;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_wdata;
  logic [N-1:0]    m_nak;
  logic [DW-1:0]   m_rdata;
  logic            s_en;
  logic            s_we;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_wdata;
  logic [DW-1:0]   s_rdata;
  logic            s_nak;

  logic [AW-1:0]   addr_tab [N];
  logic [DW-1:0]   wd1;
  logic [DW-1:0]   wd2;
  logic [DW-1:0]   wd0;
  int              cyc;
  int              n_cmp;
  int              n_fail;

  typedef struct {
    logic       rst;
    logic [2:0] en;
    logic [2:0] we;
    logic       s_nak;
    logic       exp_s_en;
    int         exp_grant;
    logic [2:0] exp_nak;
  } vec_t;

  vec_t vecs [18];

  sram_bus_arbiter #(
    .NUM_MASTERS(N),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .m_en   (m_en),
    .m_we   (m_we),
    .m_addr (m_addr),
    .m_wdata(m_wdata),
    .m_nak  (m_nak),
    .m_rdata(m_rdata),
    .s_en   (s_en),
    .s_we   (s_we),
    .s_addr (s_addr),
    .s_wdata(s_wdata),
    .s_rdata(s_rdata),
    .s_nak  (s_nak)
  );

  // Free-running clock, first rising edge at 5 ns.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign m_addr  = {addr_tab[2], addr_tab[1], addr_tab[0]};
  assign m_wdata = {wd2, wd1, wd0};

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of master and slave inputs after the falling edge.
  task automatic apply_stimulus(input logic r, input logic [2:0] en, input logic [2:0] we,
                                input logic nak, input logic [31:0] data0);
    @(negedge clk);
    rst     = r;
    m_en    = en;
    m_we    = we;
    s_nak   = nak;
    wd0     = data0;
    cyc++;
    s_rdata = 32'hA5A5_0000 + 32'(cyc);
    #1;
  endtask

  // Compare this cycle's combinational outputs against the hand-derived values.
  task automatic check_output(input string tag, input logic exp_s_en, input int g,
                              input logic [2:0] exp_nak);
    logic [31:0] exp_wd;
    cmp({tag, " s_en"}, 32'(s_en), 32'(exp_s_en));
    cmp({tag, " m_nak"}, 32'(m_nak), 32'(exp_nak));
    cmp({tag, " m_rdata"}, m_rdata, s_rdata);
    if (exp_s_en) begin
      exp_wd = (g == 0) ? wd0 : ((g == 1) ? wd1 : wd2);
      cmp({tag, " s_addr"}, s_addr, addr_tab[g]);
      cmp({tag, " s_we"}, 32'(s_we), 32'(m_we[g]));
      cmp({tag, " s_wdata"}, s_wdata, exp_wd);
    end
  endtask

  initial begin
    n_cmp       = 0;
    n_fail      = 0;
    cyc         = 0;
    rst         = 1'b1;
    m_en        = '0;
    m_we        = '0;
    s_nak       = 1'b0;
    s_rdata     = '0;
    wd0         = '0;
    wd1         = 32'h1111_1111;
    wd2         = 32'h2222_2222;
    addr_tab[0] = 32'h1F00_0000;
    addr_tab[1] = 32'h1F00_0010;
    addr_tab[2] = 32'h1F00_0020;

    // rst, en, we, s_nak, exp_s_en, exp_grant, exp_nak
    vecs[0]  = '{1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 0, 3'b000};
    vecs[1]  = '{1'b1, 3'b010, 3'b000, 1'b0, 1'b0, 0, 3'b000};
    vecs[2]  = '{1'b0, 3'b010, 3'b000, 1'b0, 1'b1, 1, 3'b000};
    vecs[3]  = '{1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 0, 3'b000};
    vecs[4]  = '{1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 0, 3'b000};
    vecs[5]  = '{1'b0, 3'b111, 3'b000, 1'b0, 1'b1, 0, 3'b000};
    vecs[6]  = '{1'b0, 3'b111, 3'b000, 1'b0, 1'b1, 1, 3'b110};
    vecs[7]  = '{1'b0, 3'b111, 3'b000, 1'b0, 1'b1, 2, 3'b101};
    vecs[8]  = '{1'b0, 3'b111, 3'b000, 1'b0, 1'b1, 0, 3'b011};
    vecs[9]  = '{1'b0, 3'b111, 3'b000, 1'b0, 1'b1, 1, 3'b110};
    vecs[10] = '{1'b0, 3'b111, 3'b000, 1'b0, 1'b1, 2, 3'b101};
    vecs[11] = '{1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 0, 3'b011};
    vecs[12] = '{1'b0, 3'b100, 3'b100, 1'b0, 1'b1, 2, 3'b000};
    vecs[13] = '{1'b0, 3'b101, 3'b100, 1'b1, 1'b1, 2, 3'b100};
    vecs[14] = '{1'b0, 3'b101, 3'b100, 1'b1, 1'b1, 2, 3'b101};
    vecs[15] = '{1'b0, 3'b101, 3'b100, 1'b1, 1'b1, 2, 3'b101};
    vecs[16] = '{1'b0, 3'b001, 3'b000, 1'b0, 1'b1, 0, 3'b001};
    vecs[17] = '{1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 0, 3'b000};

    // Single read, rotation of three continuous requesters, locked owner.
    for (int v = 0; v < 18; v++) begin
      apply_stimulus(vecs[v].rst, vecs[v].en, vecs[v].we, vecs[v].s_nak, 32'h0);
      check_output($sformatf("vec%0d", v), vecs[v].exp_s_en, vecs[v].exp_grant, vecs[v].exp_nak);
    end

    // Master 0 alone: eight back-to-back writes, no idle cycle between them.
    for (int k = 0; k < 8; k++) begin
      apply_stimulus(1'b0, 3'b001, 3'b001, 1'b0, 32'hD000_0000 + 32'(k));
      check_output($sformatf("b2b%0d", k), 1'b1, 0, 3'b000);
    end
    apply_stimulus(1'b0, 3'b000, 3'b000, 1'b0, 32'h0);
    check_output("b2b_idle", 1'b0, 0, 3'b000);
    // Pointer left at 1: masters 0 and 2 together, master 2 wins first.
    apply_stimulus(1'b0, 3'b101, 3'b000, 1'b0, 32'h0);
    check_output("rr_probe0", 1'b1, 2, 3'b000);
    apply_stimulus(1'b0, 3'b001, 3'b000, 1'b0, 32'h0);
    check_output("rr_probe1", 1'b1, 0, 3'b001);
    apply_stimulus(1'b0, 3'b000, 3'b000, 1'b0, 32'h0);
    check_output("rr_probe2", 1'b0, 0, 3'b000);

    // Reset while master 1 is locked by a slave nak.
    apply_stimulus(1'b0, 3'b010, 3'b000, 1'b0, 32'h0);
    check_output("rst_lock0", 1'b1, 1, 3'b000);
    apply_stimulus(1'b0, 3'b010, 3'b000, 1'b1, 32'h0);
    check_output("rst_lock1", 1'b1, 1, 3'b010);
    apply_stimulus(1'b1, 3'b010, 3'b000, 1'b1, 32'h0);
    check_output("rst_lock2", 1'b0, 0, 3'b000);
    apply_stimulus(1'b0, 3'b010, 3'b000, 1'b1, 32'h0);
    check_output("rst_lock3", 1'b1, 1, 3'b000);
    apply_stimulus(1'b0, 3'b000, 3'b000, 1'b0, 32'h0);
    check_output("rst_lock4", 1'b0, 0, 3'b000);

    // Owner 0 abandons its locked request while master 2 requests.
    apply_stimulus(1'b0, 3'b001, 3'b000, 1'b0, 32'h0);
    check_output("drop0", 1'b1, 0, 3'b000);
    apply_stimulus(1'b0, 3'b001, 3'b000, 1'b1, 32'h0);
    check_output("drop1", 1'b1, 0, 3'b001);
    apply_stimulus(1'b0, 3'b100, 3'b000, 1'b1, 32'h0);
    check_output("drop2", 1'b1, 2, 3'b001);
    apply_stimulus(1'b0, 3'b000, 3'b000, 1'b0, 32'h0);
    check_output("drop3", 1'b0, 0, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
